out_act_buffer: RTL



---
 rtl/out_act_buffer_if.sv | 41 ++++
 rtl/out_act_buffer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/out_act_buffer_if.sv
// rtl/out_act_buffer_if.sv - read/write/drain bus of the output-activation buffer
//
// Signals:
//   rd_en, rd_addr, rd_data        read port (1-cycle latency) toward the add stage
//   wr_en, wr_addr, wr_data        write-back port from the add stage
//   clear                          zero all entries
//   drain_start                    pulse that starts streaming all entries
//   drain_valid, drain_ready       drain handshake
//   drain_addr, drain_data, drain_last  drain payload
//   busy                           high while draining
// Modports: master = compute pipeline / router side, slave = buffer.

interface out_act_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  clear;
    logic                  drain_start;
    logic                  drain_valid;
    logic                  drain_ready;
    logic [ADDR_WIDTH-1:0] drain_addr;
    logic [DATA_WIDTH-1:0] drain_data;
    logic                  drain_last;
    logic                  busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, clear, drain_start, drain_ready,
        input  rd_data, drain_valid, drain_addr, drain_data, drain_last, busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clear, drain_start, drain_ready,
        output rd_data, drain_valid, drain_addr, drain_data, drain_last, busy
    );
endinterface

// File: rtl/out_act_buffer.sv
// rtl/out_act_buffer.sv - per-PE output-activation store with RAW forwarding and drain stream
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset (clears memory, outputs, pointers)
//   bus   out_act_buffer_if.slave: read port, write-back port, clear, drain stream, busy
// Options:
//   OUT_ACT_RELU_EN  when defined, negative entries drain as 0 (read port unaffected)

module out_act_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ACT_NO     = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    out_act_buffer_if.slave   bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ACT_NO - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [ACT_NO];
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_issued_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  drain_valid_q;
    logic                  busy_q;

    logic                  idle;
    logic                  wr_in_range;
    logic                  wr_act;
    logic                  same_fwd;
    logic                  late_fwd;
    logic [DATA_WIDTH-1:0] rd_mem;
    logic [DATA_WIDTH-1:0] rd_next;
    logic [DATA_WIDTH-1:0] drain_raw;

    // Address decode by loop so out-of-range addresses naturally read 0
    // and never hit a write.
    always_comb begin
        rd_mem      = '0;
        drain_raw   = '0;
        wr_in_range = 1'b0;
        for (int i = 0; i < ACT_NO; i++) begin
            if (bus.rd_addr == ADDR_WIDTH'(i)) rd_mem = mem[i];
            if (ptr == ADDR_WIDTH'(i))         drain_raw = mem[i];
            if (bus.wr_addr == ADDR_WIDTH'(i)) wr_in_range = 1'b1;
        end
    end

    assign idle     = (state == IDLE);
    assign wr_act   = idle && bus.wr_en && !bus.clear && wr_in_range;
    assign same_fwd = wr_act && (bus.wr_addr == bus.rd_addr);
    // A write landing one cycle after the read it would have fed.
    assign late_fwd = wr_act && rd_issued_q && (bus.wr_addr == rd_addr_q);

    // Clear and write both take effect before a same-cycle read.
    always_comb begin
        rd_next = rd_mem;
        if (idle) begin
            if (bus.clear)     rd_next = '0;
            else if (same_fwd) rd_next = bus.wr_data;
        end
    end

    // Read pipeline; a late-forwarded value is captured so rd_data keeps
    // showing it once the write has landed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q   <= '0;
            rd_issued_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_issued_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_addr_q <= bus.rd_addr;
                rd_data_q <= rd_next;
            end else if (late_fwd) begin
                rd_data_q <= bus.wr_data;
            end
        end
    end

    // Storage is frozen while draining so drain_data stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ACT_NO; i++) mem[i] <= '0;
        end else if (idle) begin
            for (int i = 0; i < ACT_NO; i++) begin
                if (bus.clear)
                    mem[i] <= '0;
                else if (wr_act && bus.wr_addr == ADDR_WIDTH'(i))
                    mem[i] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            drain_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.drain_start) begin
                        state         <= DRAIN;
                        ptr           <= '0;
                        drain_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.drain_ready) begin
                        if (ptr == LAST_ADDR) begin
                            state         <= IDLE;
                            ptr           <= '0;
                            drain_valid_q <= 1'b0;
                            busy_q        <= 1'b0;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    ptr           <= '0;
                    drain_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data     = late_fwd ? bus.wr_data : rd_data_q;
    assign bus.drain_valid = drain_valid_q;
    assign bus.busy        = busy_q;
    assign bus.drain_addr  = ptr;
    assign bus.drain_last  = drain_valid_q && (ptr == LAST_ADDR);

`ifdef OUT_ACT_RELU_EN
    assign bus.drain_data = (!drain_valid_q || drain_raw[DATA_WIDTH-1]) ? '0 : drain_raw;
`else
    assign bus.drain_data = drain_valid_q ? drain_raw : '0;
`endif

endmodule
